counter_0_to_5: RTL and testbench
=================================

// Module: counter_0_to_5
// PURPOSE
//   Synchronous 3-bit modulo-6 counter (values 0..5) with mode select and parallel load.
//   Basic digit cell of the stopwatch: drives the tens-of-seconds/minutes digit (0..5).
//   Output is the registered count as three discrete bits A2..A0 (A0 = LSB).
// PARAMETERS
//   none (modulus fixed at 6, width fixed at 3)
// PORTS
//   clk    in  1  system clock; all state updates on rising edge
//   reset  in  1  synchronous, active-high reset
//   s      in  2  mode select: 00 up, 01 down, 10 hold, 11 clear
//   load   in  1  synchronous parallel load enable, active-high
//   i0     in  1  load value bit 0 (LSB)
//   i1     in  1  load value bit 1
//   i2     in  1  load value bit 2 (MSB)
//   A0     out 1  count bit 0 (LSB)
//   A1     out 1  count bit 1
//   A2     out 1  count bit 2 (MSB)
// BEHAVIOUR
//   - One clock; reset is synchronous and active-high.
//   - Internal state q[2:0]; {A2,A1,A0} = q, driven directly from the register (no comb path).
//   - Priority per rising edge: reset > load > s.
//   - reset=1: q <= 0 at the edge; outputs read 000 from that edge on. Before the first reset
//     edge q is X in simulation.
//   - load=1: q <= {i2,i1,i0} when that value is 0..5. For 6 or 7, q <= 0 (keeps q in range).
//   - s=00 up: q <= (q==5) ? 0 : q+1. Wrap 5 -> 0.
//   - s=01 down: q <= (q==0) ? 5 : q-1. Wrap 0 -> 5.
//   - s=10 hold: q unchanged.
//   - s=11 clear: q <= 0.
//   - Latency: every change is visible one clock after the edge that samples the controls.
//     No multi-cycle operations and no handshake.
//   - Load held for several cycles reloads the same value each edge; counting resumes on the
//     first edge with load=0.
//   - Reset asserted mid-count wins over load/mode on that edge; the count restarts from 0.
//   - Invariant: q never takes 6 or 7 after the first reset or load edge.
// STRUCTURE
//   - Shared package stopwatch_pkg:
//       typedef enum logic [1:0] {MODE_UP=2'b00, MODE_DOWN=2'b01, MODE_HOLD=2'b10,
//       MODE_CLEAR=2'b11} cnt_mode_t;
//       localparam logic [2:0] CNT_MAX = 3'd5;
//   - Single always_ff for q plus an always_comb next-state block.
//   - Optional sub-module counter_0_to_5_next (pure comb: q, s, load, i -> q_next).
//     Shared with other digit cells of the stopwatch.
// TESTING  (clk period 100, rising edges at 50,150,...)
//   - reset=1 for first edge, s=00, load=0 -> A2..A0 = 000 after the edge at t=50.
//   - Release reset; s=00 -> sequence 001,010,011,100,101,000 on successive edges (wrap 5->0).
//   - load=1 with i2..i0=001 for two edges, then load=0, s=00 -> 001,001, then 010,011,100,101,000,001.
//   - Load 7 (i=111) -> q=000. Load 5, then s=01 -> 101,100,011,010,001,000,101 (wrap 0->5).
//   - Count to 3, s=10 for 3 edges -> stays 011. Then s=11 -> 000 next edge.
//   - reset=1 and load=1 (i=100) on the same edge at q=4 -> 000. Reset wins over load.
//   - Checker on every edge: {A2,A1,A0} <= 5 after the first reset edge.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch digit cells.
//   cnt_mode_t  : mode select encoding for the 0..5 digit counter
//   CNT_MAX     : largest legal digit value (modulus 6)
//   clamp_load  : maps an out-of-range parallel load value to 0
package stopwatch_pkg;

    typedef enum logic [1:0] {
        MODE_UP    = 2'b00,
        MODE_DOWN  = 2'b01,
        MODE_HOLD  = 2'b10,
        MODE_CLEAR = 2'b11
    } cnt_mode_t;

    localparam logic [2:0] CNT_MAX = 3'd5;

    // Loading 6 or 7 would leave the digit out of range, so those values become 0.
    function automatic logic [2:0] clamp_load(input logic [2:0] v);
        logic [2:0] r;
        if (v > CNT_MAX) begin
            r = 3'd0;
        end else begin
            r = v;
        end
        return r;
    endfunction

endpackage

// File: rtl/counter_0_to_5_next.sv
// Next-state logic for a 0..5 digit cell (pure combinational, shared by digit cells).
// Ports:
//   q       in  3  current count
//   s       in  2  mode select (up, down, hold, clear)
//   load    in  1  parallel load enable, has priority over s
//   i       in  3  parallel load value
//   q_next  out 3  count to be registered at the next edge
module counter_0_to_5_next
    import stopwatch_pkg::*;
(
    input  logic [2:0] q,
    input  logic [1:0] s,
    input  logic       load,
    input  logic [2:0] i,
    output logic [2:0] q_next
);

    cnt_mode_t mode_s;

    assign mode_s = cnt_mode_t'(s);

    // Select the next count: load first, otherwise the requested mode.
    always_comb begin
        q_next = q;
        if (load) begin
            q_next = clamp_load(i);
        end else begin
            case (mode_s)
                MODE_UP: begin
                    if (q == CNT_MAX) begin
                        q_next = 3'd0;
                    end else begin
                        q_next = q + 3'd1;
                    end
                end
                MODE_DOWN: begin
                    if (q == 3'd0) begin
                        q_next = CNT_MAX;
                    end else begin
                        q_next = q - 3'd1;
                    end
                end
                MODE_HOLD: begin
                    q_next = q;
                end
                MODE_CLEAR: begin
                    q_next = 3'd0;
                end
                default: begin
                    q_next = 3'd0;
                end
            endcase
        end
    end

endmodule

// File: rtl/counter_0_to_5.sv
// Modulo-6 digit counter (0..5) with mode select and parallel load; the
// tens-of-seconds / tens-of-minutes digit of the stopwatch.
// Ports:
//   clk    in  1  clock, rising edge
//   reset  in  1  synchronous active-high reset (beats load and mode)
//   s      in  2  mode: 00 up, 01 down, 10 hold, 11 clear
//   load   in  1  parallel load enable (beats mode)
//   i0..i2 in  1  load value bits, i0 = LSB
//   A0..A2 out 1  registered count bits, A0 = LSB
module counter_0_to_5
    import stopwatch_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] s,
    input  logic       load,
    input  logic       i0,
    input  logic       i1,
    input  logic       i2,
    output logic       A0,
    output logic       A1,
    output logic       A2
);

    logic [2:0] q_r;
    logic [2:0] q_next_s;
    logic [2:0] load_val_s;

    assign load_val_s = {i2, i1, i0};

    counter_0_to_5_next u_next (
        .q      (q_r),
        .s      (s),
        .load   (load),
        .i      (load_val_s),
        .q_next (q_next_s)
    );

    // Count register; reset is sampled on the clock edge only.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_r <= 3'd0;
        end else begin
            q_r <= q_next_s;
        end
    end

    // Outputs come straight from the register, no combinational path.
    assign {A2, A1, A0} = q_r;

endmodule

// File: tb/tb_counter_0_to_5.sv
// Scoreboard bench for counter_0_to_5: the driver computes the expected digit
// with mod-6 arithmetic and queues it; the monitor compares after each edge.
module tb_counter_0_to_5;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] s;
    logic       load;
    logic       i0, i1, i2;
    logic       A0, A1, A2;

    int exp_q[$];
    int vectors = 0;
    int miscompares = 0;
    int model = 0;
    bit driving_done = 1'b0;

    counter_0_to_5 dut (
        .clk   (clk),
        .reset (reset),
        .s     (s),
        .load  (load),
        .i0    (i0),
        .i1    (i1),
        .i2    (i2),
        .A0    (A0),
        .A1    (A1),
        .A2    (A2)
    );

    always #50 clk = ~clk;

    // Apply one set of controls for one edge and queue the expected result.
    task automatic step(input bit r, input int mode, input bit ld, input int v);
        reset = r;
        s     = mode[1:0];
        load  = ld;
        {i2, i1, i0} = v[2:0];
        if (r) begin
            model = 0;
        end else if (ld) begin
            model = (v < 6) ? v : 0;
        end else begin
            case (mode)
                0:       model = (model + 1) % 6;
                1:       model = (model + 5) % 6;
                2:       model = model;
                default: model = 0;
            endcase
        end
        exp_q.push_back(model);
        @(posedge clk);
        @(negedge clk);
    endtask

    // Monitor: compare DUT output to the oldest queued expectation after each edge.
    initial begin
        int got;
        int exp;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                got = int'({A2, A1, A0});
                exp = exp_q.pop_front();
                vectors++;
                if (got != exp) begin
                    miscompares++;
                    $display("FAIL count: got %0d expected %0d at t=%0t", got, exp, $time);
                end
                vectors++;
                if (got > 5) begin
                    miscompares++;
                    $display("FAIL range: got %0d required <= 5 at t=%0t", got, $time);
                end
            end
        end
    end

    // Directed scenarios followed by randomized stimulus.
    initial begin
        step(1, 0, 0, 0);                          // reset -> 0
        for (int k = 0; k < 6; k++) step(0, 0, 0, 0);   // 1..5, wrap to 0
        step(0, 0, 1, 1);                          // load 1 twice
        step(0, 0, 1, 1);
        for (int k = 0; k < 6; k++) step(0, 0, 0, 0);   // 2,3,4,5,0,1
        step(0, 0, 1, 7);                          // load 7 -> 0
        step(0, 0, 1, 6);                          // load 6 -> 0
        step(0, 0, 1, 5);                          // load 5
        for (int k = 0; k < 6; k++) step(0, 1, 0, 0);   // 4..0, wrap to 5
        step(0, 3, 0, 0);                          // clear
        for (int k = 0; k < 3; k++) step(0, 0, 0, 0);   // up to 3
        for (int k = 0; k < 3; k++) step(0, 2, 0, 0);   // hold at 3
        step(0, 3, 0, 0);                          // clear -> 0
        step(0, 0, 1, 4);                          // q = 4
        step(1, 0, 1, 4);                          // reset beats load -> 0
        for (int k = 0; k < 400; k++) begin
            step(($urandom_range(15) == 0),
                 int'($urandom_range(3)),
                 ($urandom_range(4) == 0),
                 int'($urandom_range(7)));
        end
        driving_done = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
